// File: rtl/sh7034_ibus_master.sv
// sh7034_ibus_master
//   Initiator side of the SH7034 internal peripheral bus (IBUS). Turns a
//   byte/word/long read/write command into one IBUS cycle. It steers the
//   byte lanes big-endian, waits out responder BUSY, and reports misaligned
//   or illegal commands, unclaimed addresses and wait-state timeouts.
//
// Parameters
//   Timeout   max CE_R samples with busy=1 before the cycle is aborted (1..255)
//   CheckAct  1: completion without ibus_act_i is reported as an error
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   ce_r_i                 rising-phase enable; all state advances on it
//   ce_f_i                 falling-phase enable (responder timing only)
//   cmd_req_i .. cmd_wdata_i  command request, held until cmd_ack_o
//   cmd_ack_o              one-clock completion pulse
//   cmd_rdata_o, cmd_err_o read data (right-justified) and error, valid with ack
//   ibus_a_o, ibus_do_o, ibus_ba_o, ibus_we_o, ibus_req_o  bus cycle outputs
//   ibus_di_i, ibus_busy_i, ibus_act_i                     responder inputs
module sh7034_ibus_master #(
    parameter int unsigned Timeout  = 255,
    parameter bit          CheckAct = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_r_i,
    input  logic        ce_f_i,
    input  logic        cmd_req_i,
    input  logic [27:0] cmd_addr_i,
    input  logic        cmd_we_i,
    input  logic [1:0]  cmd_size_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        cmd_ack_o,
    output logic [31:0] cmd_rdata_o,
    output logic        cmd_err_o,
    output logic [27:0] ibus_a_o,
    output logic [31:0] ibus_do_o,
    input  logic [31:0] ibus_di_i,
    output logic [3:0]  ibus_ba_o,
    output logic        ibus_we_o,
    output logic        ibus_req_o,
    input  logic        ibus_busy_i,
    input  logic        ibus_act_i
);

    localparam logic [7:0] CntMax = 8'(Timeout - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [27:0] a_q, a_d;
    logic [31:0] do_q, do_d;
    logic [3:0]  ba_q, ba_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        misaligned;
    logic [3:0]  lane_ba;
    logic [31:0] lane_do;
    logic [31:0] lane_rd;

    // ce_f_i only describes when responders sample; no logic depends on it.
    logic unused_ce_f;
    assign unused_ce_f = ce_f_i;

    // Lane steering for the incoming command.
    always_comb begin
        misaligned = 1'b0;
        lane_ba    = 4'b1111;
        lane_do    = cmd_wdata_i;
        unique case (cmd_size_i)
            2'd0: begin
                lane_ba = 4'b1000 >> cmd_addr_i[1:0];
                lane_do = {4{cmd_wdata_i[7:0]}};
            end
            2'd1: begin
                lane_ba    = cmd_addr_i[1] ? 4'b0011 : 4'b1100;
                lane_do    = {2{cmd_wdata_i[15:0]}};
                misaligned = cmd_addr_i[0];
            end
            2'd2: misaligned = (cmd_addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Pick the active read lane(s) and right-justify them.
    always_comb begin
        case (ba_q)
            4'b1000: lane_rd = {24'h0, ibus_di_i[31:24]};
            4'b0100: lane_rd = {24'h0, ibus_di_i[23:16]};
            4'b0010: lane_rd = {24'h0, ibus_di_i[15:8]};
            4'b0001: lane_rd = {24'h0, ibus_di_i[7:0]};
            4'b1100: lane_rd = {16'h0, ibus_di_i[31:16]};
            4'b0011: lane_rd = {16'h0, ibus_di_i[15:0]};
            default: lane_rd = ibus_di_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;  // pulse clears on every clock, even with ce_r_i low
        err_d   = err_q;
        rdata_d = rdata_q;
        a_d     = a_q;
        do_d    = do_q;
        ba_d    = ba_q;
        we_d    = we_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        if (ce_r_i) begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_req_i) begin
                        if (misaligned) begin
                            ack_d   = 1'b1;
                            err_d   = 1'b1;
                            rdata_d = 32'h0;
                        end else begin
                            a_d     = cmd_addr_i;
                            we_d    = cmd_we_i;
                            ba_d    = lane_ba;
                            do_d    = lane_do;
                            req_d   = 1'b1;
                            cnt_d   = 8'h0;
                            state_d = StAccess;
                        end
                    end
                end
                StAccess: begin
                    if (ibus_busy_i) begin
                        if (cnt_q == CntMax) begin
                            req_d   = 1'b0;
                            ack_d   = 1'b1;
                            err_d   = 1'b1;
                            rdata_d = 32'h0;
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        req_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = StIdle;
                        if (CheckAct && !ibus_act_i) begin
                            err_d   = 1'b1;
                            rdata_d = 32'h0;
                        end else begin
                            err_d   = 1'b0;
                            rdata_d = we_q ? 32'h0 : lane_rd;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            a_q     <= 28'h0;
            do_q    <= 32'h0;
            ba_q    <= 4'h0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            a_q     <= a_d;
            do_q    <= do_d;
            ba_q    <= ba_d;
            we_q    <= we_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ack_o   = ack_q;
    assign cmd_err_o   = err_q;
    assign cmd_rdata_o = rdata_q;
    assign ibus_a_o    = a_q;
    assign ibus_do_o   = do_q;
    assign ibus_ba_o   = ba_q;
    assign ibus_we_o   = we_q;
    assign ibus_req_o  = req_q;

endmodule

// File: tb/tb_sh7034_ibus_master.sv
// Bench for sh7034_ibus_master: table of commands checked through a
// completion scoreboard, plus hand sequences for CE_R gating and reset abort.
module tb_sh7034_ibus_master;

    logic        clk = 1'b0;
    logic        rst, ce_r, ce_f, cmd_req, cmd_we, ibus_busy, ibus_act;
    logic [27:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata, ibus_di;

    logic        ack1, err1, we1, req1, ack2, err2, we2, req2;
    logic [31:0] rdata1, do1, rdata2, do2;
    logic [27:0] a1, a2;
    logic [3:0]  ba1, ba2;

    logic        sel;
    logic        ack_m, err_m, we_m, req_m;
    logic [31:0] rdata_m, do_m;
    logic [27:0] a_m;
    logic [3:0]  ba_m;

    always #5 clk = ~clk;

    sh7034_ibus_master #(.Timeout(255), .CheckAct(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .ce_r_i(ce_r), .ce_f_i(ce_f),
        .cmd_req_i(cmd_req), .cmd_addr_i(cmd_addr), .cmd_we_i(cmd_we),
        .cmd_size_i(cmd_size), .cmd_wdata_i(cmd_wdata),
        .cmd_ack_o(ack1), .cmd_rdata_o(rdata1), .cmd_err_o(err1),
        .ibus_a_o(a1), .ibus_do_o(do1), .ibus_di_i(ibus_di), .ibus_ba_o(ba1),
        .ibus_we_o(we1), .ibus_req_o(req1), .ibus_busy_i(ibus_busy), .ibus_act_i(ibus_act)
    );

    sh7034_ibus_master #(.Timeout(4), .CheckAct(1'b1)) u_dut_to4 (
        .clk_i(clk), .rst_i(rst), .ce_r_i(ce_r), .ce_f_i(ce_f),
        .cmd_req_i(cmd_req), .cmd_addr_i(cmd_addr), .cmd_we_i(cmd_we),
        .cmd_size_i(cmd_size), .cmd_wdata_i(cmd_wdata),
        .cmd_ack_o(ack2), .cmd_rdata_o(rdata2), .cmd_err_o(err2),
        .ibus_a_o(a2), .ibus_do_o(do2), .ibus_di_i(ibus_di), .ibus_ba_o(ba2),
        .ibus_we_o(we2), .ibus_req_o(req2), .ibus_busy_i(ibus_busy), .ibus_act_i(ibus_act)
    );

    assign ack_m   = sel ? ack2 : ack1;
    assign err_m   = sel ? err2 : err1;
    assign we_m    = sel ? we2 : we1;
    assign req_m   = sel ? req2 : req1;
    assign rdata_m = sel ? rdata2 : rdata1;
    assign do_m    = sel ? do2 : do1;
    assign a_m     = sel ? a2 : a1;
    assign ba_m    = sel ? ba2 : ba1;

    typedef struct {
        logic [27:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] di;
        int          busy;   // CE_R samples with busy=1 after acceptance
        logic        act;
        logic        sel;    // 1: Timeout=4 instance
        logic        bus;    // a bus cycle is expected
        logic [3:0]  ba;
        logic [31:0] dout;
        logic        err;
        logic [31:0] rdata;
        int          lat;    // clocks with ibus_req high
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   samples = 0;
        bit   seen    = 0;
        bit   done    = 0;
        int   left    = v.busy;
        exp_t e;
        sel       = v.sel;
        cmd_addr  = v.addr;
        cmd_we    = v.we;
        cmd_size  = v.size;
        cmd_wdata = v.wdata;
        ibus_di   = v.di;
        ibus_act  = v.act;
        ibus_busy = 1'b0;
        cmd_req   = 1'b1;
        e.err     = v.err;
        e.rdata   = v.rdata;
        sb.push_back(e);
        for (int c = 0; c < 600 && !done; c++) begin
            @(posedge clk); #1;
            if (ack_m) begin
                cmd_req = 1'b0;
                done    = 1;
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL v%0d unexpected ack: got ack expected none", idx);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d err", idx), {31'h0, err_m}, {31'h0, e.err});
                    check($sformatf("v%0d rdata", idx), rdata_m, e.rdata);
                end
                check($sformatf("v%0d req low at ack", idx), {31'h0, req_m}, 32'h0);
                check($sformatf("v%0d req cycles", idx), samples, v.lat);
                if (v.bus) check($sformatf("v%0d ba held", idx), {28'h0, ba_m}, {28'h0, v.ba});
            end else if (req_m) begin
                samples++;
                if (!seen) begin
                    seen = 1;
                    check($sformatf("v%0d ba", idx), {28'h0, ba_m}, {28'h0, v.ba});
                    check($sformatf("v%0d do", idx), do_m, v.dout);
                    check($sformatf("v%0d we", idx), {31'h0, we_m}, {31'h0, v.we});
                    check($sformatf("v%0d a", idx), {4'h0, a_m}, {4'h0, v.addr});
                end
                ibus_busy = (left > 0);
                if (left > 0) left--;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL v%0d no ack: got none expected ack within 600 clocks", idx);
            void'(sb.pop_front());
            cmd_req = 1'b0;
        end
        ibus_busy = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d ack pulse", idx), {31'h0, ack_m}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr          we    sz    wdata         di            bsy act  sel  bus  ba    dout          err   rdata        lat
        vecs[0]  = '{28'h5FFFFB8, 1'b1, 2'd1, 32'h00005A40, 32'h0,        0,  1'b1, 1'b0, 1'b1, 4'hC, 32'h5A405A40, 1'b0, 32'h0,        1};
        vecs[1]  = '{28'h5FFFFB9, 1'b0, 2'd0, 32'h12345678, 32'h00A000A0, 0,  1'b1, 1'b0, 1'b1, 4'h4, 32'h78787878, 1'b0, 32'h000000A0, 1};
        vecs[2]  = '{28'h5FFFFBA, 1'b0, 2'd2, 32'h0,        32'h0,        0,  1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        0};
        vecs[3]  = '{28'h5FFFFBA, 1'b0, 2'd1, 32'h0000CAFE, 32'hDEADBEEF, 3,  1'b1, 1'b0, 1'b1, 4'h3, 32'hCAFECAFE, 1'b0, 32'h0000BEEF, 4};
        vecs[4]  = '{28'h5FFFFBC, 1'b1, 2'd2, 32'h11223344, 32'hFFFFFFFF, 0,  1'b1, 1'b0, 1'b1, 4'hF, 32'h11223344, 1'b0, 32'h0,        1};
        vecs[5]  = '{28'h5FFFFBB, 1'b0, 2'd0, 32'h0,        32'hAABBCCDD, 1,  1'b1, 1'b0, 1'b1, 4'h1, 32'h0,        1'b0, 32'h000000DD, 2};
        vecs[6]  = '{28'h5FFFFB8, 1'b0, 2'd0, 32'h000000E7, 32'hAABBCCDD, 0,  1'b1, 1'b0, 1'b1, 4'h8, 32'hE7E7E7E7, 1'b0, 32'h000000AA, 1};
        vecs[7]  = '{28'h5FFFFBC, 1'b0, 2'd2, 32'h0,        32'hAABBCCDD, 0,  1'b0, 1'b0, 1'b1, 4'hF, 32'h0,        1'b1, 32'h0,        1};
        vecs[8]  = '{28'h5FFFFB8, 1'b0, 2'd3, 32'h0,        32'h0,        0,  1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        0};
        vecs[9]  = '{28'h5FFFFB9, 1'b1, 2'd1, 32'h0,        32'h0,        0,  1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        0};
        vecs[10] = '{28'h5FFFFB8, 1'b0, 2'd1, 32'h0,        32'h12345678, 50, 1'b1, 1'b1, 1'b1, 4'hC, 32'h0,        1'b1, 32'h0,        4};

        rst = 1'b1; ce_r = 1'b1; ce_f = 1'b0; cmd_req = 1'b0; cmd_we = 1'b0;
        cmd_addr = '0; cmd_size = '0; cmd_wdata = '0; ibus_di = '0;
        ibus_busy = 1'b0; ibus_act = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'h0, ack_m}, 32'h0);
        check("reset err", {31'h0, err_m}, 32'h0);
        check("reset rdata", rdata_m, 32'h0);
        check("reset req", {31'h0, req_m}, 32'h0);
        check("reset we", {31'h0, we_m}, 32'h0);
        check("reset a", {4'h0, a_m}, 32'h0);
        check("reset do", do_m, 32'h0);
        check("reset ba", {28'h0, ba_m}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // CE_R gating: nothing moves with ce_r low except the ack pulse clearing.
        sel = 1'b0; ce_r = 1'b0;
        cmd_addr = 28'h5FFFFB4; cmd_we = 1'b1; cmd_size = 2'd1; cmd_wdata = 32'h1234;
        ibus_busy = 1'b0; ibus_act = 1'b1; cmd_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("gate no accept", {31'h0, req_m}, 32'h0);
        ce_r = 1'b1;
        @(posedge clk); #1;
        check("gate accept", {31'h0, req_m}, 32'h1);
        ce_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("gate hold req", {31'h0, req_m}, 32'h1);
            check("gate hold ack", {31'h0, ack_m}, 32'h0);
        end
        ce_r = 1'b1;
        @(posedge clk); #1;
        check("gate ack", {31'h0, ack_m}, 32'h1);
        check("gate req drop", {31'h0, req_m}, 32'h0);
        cmd_req = 1'b0; ce_r = 1'b0;
        @(posedge clk); #1;
        check("gate ack clears", {31'h0, ack_m}, 32'h0);
        check("gate ba held", {28'h0, ba_m}, 32'hC);
        check("gate do held", do_m, 32'h12341234);
        ce_r = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset during ACCESS: request drops, command inputs ignored, no ack.
        cmd_addr = 28'h5FFFFBC; cmd_we = 1'b0; cmd_size = 2'd2; ibus_busy = 1'b1;
        cmd_req = 1'b1;
        @(posedge clk); #1;
        check("rst accept", {31'h0, req_m}, 32'h1);
        cmd_addr = 28'h0000010; cmd_size = 2'd0;
        @(posedge clk); #1;
        check("cmd change ignored", {4'h0, a_m}, 32'h05FFFFBC);
        cmd_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("rst req drop", {31'h0, req_m}, 32'h0);
        check("rst no ack", {31'h0, ack_m}, 32'h0);
        rst = 1'b0; ibus_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst stays quiet", {31'h0, ack_m | req_m}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
